// File: rtl/ssm_funnel_shifter_gen.sv
// Substream funnel shifter: accumulates variable-size mux words into an MSB-aligned bit
// buffer and removes parser-consumed bits each cycle. Optional feature macro: SSM_FS_ERR_CHECK_EN.
module ssm_funnel_shifter_gen #(
    parameter int MUX_WORD_W = 256,
    parameter int MAX_SE_W   = 248,
    parameter int FS_W       = 2*MAX_SE_W-1,
    parameter int FULL_W     = $clog2(FS_W+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  en_funnel_shifter,
    input  logic [7:0]            ssm_max_se_size,
    output logic                  mux_word_request,
    input  logic                  mux_word_valid,
    input  logic [MUX_WORD_W-1:0] mux_word,
    output logic [FS_W-1:0]       data_to_be_parsed,
    output logic [FULL_W-1:0]     fullness,
    output logic                  ready,
    input  logic [FULL_W-1:0]     size_to_remove,
    input  logic                  size_to_remove_valid,
    output logic                  err_underflow
);

    localparam int AW = FULL_W + 1;

    logic [FS_W-1:0]       buf_q, buf_d;
    logic [FULL_W-1:0]     fullness_q, fullness_d;
    logic                  ready_q, ready_d;

    logic [AW-1:0]         se_ext_s;
    logic [AW-1:0]         fullness_ext_s;
    logic [AW-1:0]         pull_raw_s;
    logic [AW-1:0]         pull_s;
    logic [AW-1:0]         f1_s;
    logic [AW-1:0]         shamt_s;
    logic                  push_s;
    logic [MUX_WORD_W-1:0] word_masked_s;
    logic [FS_W-1:0]       word_ext_s;
    logic [FS_W-1:0]       shifted_s;

    assign se_ext_s       = AW'(ssm_max_se_size);
    assign fullness_ext_s = {1'b0, fullness_q};
    assign pull_raw_s     = size_to_remove_valid ? {1'b0, size_to_remove} : {AW{1'b0}};

    // Request depends only on registered fullness, never on the current pull.
    assign mux_word_request = en_funnel_shifter & ~flush & ~rst
                              & ((fullness_ext_s + se_ext_s) <= AW'(FS_W));
    assign push_s = mux_word_valid & mux_word_request;

`ifdef SSM_FS_ERR_CHECK_EN
    logic err_q, err_d;
    logic underflow_s;

    assign underflow_s = (pull_raw_s > fullness_ext_s);
    assign pull_s      = underflow_s ? fullness_ext_s : pull_raw_s;

    // Sticky underflow flag; held while the block is disabled.
    always_comb begin
        err_d = err_q;
        if (en_funnel_shifter) begin
            err_d = err_q | underflow_s;
        end else begin
            err_d = err_q;
        end
    end

    // Underflow flag register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_underflow = err_q;
`else
    assign pull_s        = pull_raw_s;
    assign err_underflow = 1'b0;
`endif

    assign f1_s      = fullness_ext_s - pull_s;
    assign shifted_s = buf_q << pull_s;
    assign shamt_s   = AW'(FS_W) - f1_s - se_ext_s;

    // Unused upper mux-word bits are forced to zero so stale data never enters the buffer.
    assign word_masked_s = mux_word & ~({MUX_WORD_W{1'b1}} << ssm_max_se_size);

    generate
        if (MUX_WORD_W >= FS_W) begin : g_word_trunc
            assign word_ext_s = word_masked_s[FS_W-1:0];
        end else begin : g_word_zext
            assign word_ext_s = {{(FS_W-MUX_WORD_W){1'b0}}, word_masked_s};
        end
    endgenerate

    // Next-state: pull first, then append the pushed word directly below the remaining bits.
    always_comb begin
        buf_d      = buf_q;
        fullness_d = fullness_q;
        ready_d    = ready_q;
        if (en_funnel_shifter) begin
            ready_d = (fullness_ext_s >= se_ext_s);
            if (push_s) begin
                buf_d      = shifted_s | (word_ext_s << shamt_s);
                fullness_d = FULL_W'(f1_s + se_ext_s);
            end else begin
                buf_d      = shifted_s;
                fullness_d = FULL_W'(f1_s);
            end
        end else begin
            buf_d      = buf_q;
            fullness_d = fullness_q;
            ready_d    = ready_q;
        end
    end

    // State registers; rst and flush both clear synchronously.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            buf_q      <= {FS_W{1'b0}};
            fullness_q <= {FULL_W{1'b0}};
            ready_q    <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            fullness_q <= fullness_d;
            ready_q    <= ready_d;
        end
    end

    assign data_to_be_parsed = buf_q;
    assign fullness          = fullness_q;
    assign ready             = ready_q;

endmodule

// File: tb/tb_ssm_funnel_shifter_gen.sv
// Directed self-checking bench for ssm_funnel_shifter_gen with default parameters.
module tb_ssm_funnel_shifter_gen;

    localparam int MUX_WORD_W = 256;
    localparam int FS_W       = 495;
    localparam int FULL_W     = 9;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic                  en;
    logic [7:0]            se;
    logic                  req;
    logic                  valid;
    logic [MUX_WORD_W-1:0] word;
    logic [FS_W-1:0]       data;
    logic [FULL_W-1:0]     fullness;
    logic                  ready;
    logic [FULL_W-1:0]     size;
    logic                  size_valid;
    logic                  err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [FS_W-1:0] exp_data;
    logic [99:0]     w100;

    always #5 clk = ~clk;

    ssm_funnel_shifter_gen dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .en_funnel_shifter    (en),
        .ssm_max_se_size      (se),
        .mux_word_request     (req),
        .mux_word_valid       (valid),
        .mux_word             (word),
        .data_to_be_parsed    (data),
        .fullness             (fullness),
        .ready                (ready),
        .size_to_remove       (size),
        .size_to_remove_valid (size_valid),
        .err_underflow        (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic set_se(input logic [7:0] v);
        en = 1'b0;
        se = v;
        tick();
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; valid = 1'b1; se = 8'd8;
        tick();
        tick();
        tests_run++; if (req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got=%0b exp=0", req); end
        tests_run++; if (data !== {FS_W{1'b0}}) begin tests_failed++; $display("FAIL reset_data got=%h exp=0", data); end
        tests_run++; if (fullness !== 9'd0) begin tests_failed++; $display("FAIL reset_fullness got=%0d exp=0", fullness); end
        tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got=%0b exp=0", ready); end
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got=%0b exp=0", err); end
        rst = 1'b0; valid = 1'b0;
    endtask

    task automatic test_fill_248();
        se = 8'd248;
        word = {8'hEE, {31{8'hA5}}};
        valid = 1'b1;
        #1;
        tests_run++; if (req !== 1'b1) begin tests_failed++; $display("FAIL fill_req_t0 got=%0b exp=1", req); end
        tick();
        exp_data = {{31{8'hA5}}, 247'd0};
        tests_run++; if (fullness !== 9'd248) begin tests_failed++; $display("FAIL fill_fullness_t1 got=%0d exp=248", fullness); end
        tests_run++; if (req !== 1'b0) begin tests_failed++; $display("FAIL fill_req_t1 got=%0b exp=0", req); end
        tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL fill_ready_t1 got=%0b exp=0", ready); end
        tests_run++; if (data !== exp_data) begin tests_failed++; $display("FAIL fill_data got=%h exp=%h", data, exp_data); end
        tick();
        tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL fill_ready_t2 got=%0b exp=1", ready); end
        tests_run++; if (fullness !== 9'd248) begin tests_failed++; $display("FAIL fill_fullness_t2 got=%0d exp=248", fullness); end
        valid = 1'b0;
        do_flush();
        tests_run++; if (fullness !== 9'd0) begin tests_failed++; $display("FAIL fill_flush got=%0d exp=0", fullness); end
    endtask

    task automatic test_push_small();
        set_se(8'd8);
        valid = 1'b1;
        word = {{31{8'hFF}}, 8'hA5};
        tick();
        word = {{31{8'h11}}, 8'h3C};
        tick();
        valid = 1'b0;
        tests_run++; if (fullness !== 9'd16) begin tests_failed++; $display("FAIL small_fullness got=%0d exp=16", fullness); end
        tests_run++; if (data[494:479] !== 16'hA53C) begin tests_failed++; $display("FAIL small_top got=%h exp=a53c", data[494:479]); end
        tests_run++; if (data[478:0] !== 479'd0) begin tests_failed++; $display("FAIL small_low got=%h exp=0", data[478:0]); end
    endtask

    task automatic test_push_pull();
        size = 9'd4; size_valid = 1'b1;
        valid = 1'b1; word = {{31{8'h00}}, 8'hFF};
        tick();
        valid = 1'b0; size_valid = 1'b0;
        tests_run++; if (fullness !== 9'd20) begin tests_failed++; $display("FAIL pp_fullness got=%0d exp=20", fullness); end
        tests_run++; if (data[494:475] !== 20'h53CFF) begin tests_failed++; $display("FAIL pp_top got=%h exp=53cff", data[494:475]); end
        tests_run++; if (data[474:0] !== 475'd0) begin tests_failed++; $display("FAIL pp_low got=%h exp=0", data[474:0]); end
    endtask

    task automatic test_back_to_back();
        size_valid = 1'b1;
        size = 9'd4;
        tick();
        tests_run++; if (fullness !== 9'd16) begin tests_failed++; $display("FAIL b2b_f1 got=%0d exp=16", fullness); end
        tests_run++; if (data[494:479] !== 16'h3CFF) begin tests_failed++; $display("FAIL b2b_d1 got=%h exp=3cff", data[494:479]); end
        size = 9'd8;
        tick();
        tests_run++; if (fullness !== 9'd8) begin tests_failed++; $display("FAIL b2b_f2 got=%0d exp=8", fullness); end
        tests_run++; if (data[494:487] !== 8'hFF) begin tests_failed++; $display("FAIL b2b_d2 got=%h exp=ff", data[494:487]); end
        size = 9'd0;
        tick();
        tests_run++; if (fullness !== 9'd8) begin tests_failed++; $display("FAIL b2b_zero_pull got=%0d exp=8", fullness); end
        size = 9'd8;
        tick();
        size_valid = 1'b0;
        tests_run++; if (fullness !== 9'd0) begin tests_failed++; $display("FAIL b2b_empty_f got=%0d exp=0", fullness); end
        tests_run++; if (data !== {FS_W{1'b0}}) begin tests_failed++; $display("FAIL b2b_empty_d got=%h exp=0", data); end
    endtask

    task automatic test_no_request();
        do_flush();
        set_se(8'd100);
        w100 = 100'hABCDE123456789ABCDEF01234;
        word = {{156{1'b1}}, w100};
        valid = 1'b1;
        tick(); tick(); tick();
        valid = 1'b0;
        exp_data = {w100, w100, w100, 195'd0};
        tests_run++; if (fullness !== 9'd300) begin tests_failed++; $display("FAIL noreq_fill got=%0d exp=300", fullness); end
        tests_run++; if (data !== exp_data) begin tests_failed++; $display("FAIL noreq_fill_data got=%h exp=%h", data, exp_data); end
        set_se(8'd248);
        #1;
        tests_run++; if (req !== 1'b0) begin tests_failed++; $display("FAIL noreq_req got=%0b exp=0", req); end
        valid = 1'b1;
        tick();
        tick();
        valid = 1'b0;
        tests_run++; if (fullness !== 9'd300) begin tests_failed++; $display("FAIL noreq_fullness got=%0d exp=300", fullness); end
        tests_run++; if (data !== exp_data) begin tests_failed++; $display("FAIL noreq_data got=%h exp=%h", data, exp_data); end
        en = 1'b0; valid = 1'b1; size_valid = 1'b1; size = 9'd5;
        #1;
        tests_run++; if (req !== 1'b0) begin tests_failed++; $display("FAIL en_low_req got=%0b exp=0", req); end
        tick();
        tests_run++; if (fullness !== 9'd300) begin tests_failed++; $display("FAIL en_low_fullness got=%0d exp=300", fullness); end
        en = 1'b1; valid = 1'b0; size_valid = 1'b0;
        do_flush();
    endtask

    task automatic test_flush();
        set_se(8'd120);
        word = {MUX_WORD_W{1'b1}};
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL flush_ready_lag got=%0b exp=0", ready); end
        tick();
        tests_run++; if (fullness !== 9'd120) begin tests_failed++; $display("FAIL flush_pre_f got=%0d exp=120", fullness); end
        tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL flush_pre_ready got=%0b exp=1", ready); end
        flush = 1'b1; valid = 1'b1; size_valid = 1'b1; size = 9'd5;
        #1;
        tests_run++; if (req !== 1'b0) begin tests_failed++; $display("FAIL flush_req got=%0b exp=0", req); end
        tick();
        flush = 1'b0; valid = 1'b0; size_valid = 1'b0;
        tests_run++; if (fullness !== 9'd0) begin tests_failed++; $display("FAIL flush_fullness got=%0d exp=0", fullness); end
        tests_run++; if (data !== {FS_W{1'b0}}) begin tests_failed++; $display("FAIL flush_data got=%h exp=0", data); end
        tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL flush_ready got=%0b exp=0", ready); end
    endtask

    task automatic test_underflow();
        set_se(8'd10);
        word = {MUX_WORD_W{1'b1}};
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tests_run++; if (fullness !== 9'd10) begin tests_failed++; $display("FAIL uf_pre got=%0d exp=10", fullness); end
        size = 9'd12; size_valid = 1'b1;
        tick();
        size_valid = 1'b0;
`ifdef SSM_FS_ERR_CHECK_EN
        tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL uf_err got=%0b exp=1", err); end
        tests_run++; if (fullness !== 9'd0) begin tests_failed++; $display("FAIL uf_fullness got=%0d exp=0", fullness); end
        tests_run++; if (data !== {FS_W{1'b0}}) begin tests_failed++; $display("FAIL uf_data got=%h exp=0", data); end
        tick();
        tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL uf_sticky got=%0b exp=1", err); end
`else
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL uf_err_tied got=%0b exp=0", err); end
`endif
        do_flush();
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL uf_clear got=%0b exp=0", err); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; en = 1'b0; se = 8'd8;
        valid = 1'b0; word = {MUX_WORD_W{1'b0}};
        size = 9'd0; size_valid = 1'b0;
        test_reset();
        test_fill_248();
        test_push_small();
        test_push_pull();
        test_back_to_back();
        test_no_request();
        test_flush();
        test_underflow();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ssm_funnel_shifter_gen.md
# ssm_funnel_shifter_gen

Parametrised substream funnel shifter for the decoder's entropy-decode front end. Sits between the rate-control mux-word distributor and one substream parser, accumulating variable-size mux words into a bit buffer and presenting the next unparsed bits MSB-aligned. It removes a parser-supplied number of bits per cycle. This generation adds:
- generic buffer and mux-word widths
- a same-cycle valid/request handshake
- deterministic zero-fill of invalid bits
- an exported fullness count
- optional underflow detection

## Interface
Parameters:
- MUX_WORD_W, 256, width of the mux_word bus.
- MAX_SE_W, 248, maximum legal ssm_max_se_size; must be ≤ MUX_WORD_W.
- FS_W, 2*MAX_SE_W-1, funnel buffer size in bits.
- FULL_W, $clog2(FS_W+1), width of fullness and size_to_remove.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  synchronous clear at slice end; same effect as rst.
- en_funnel_shifter  in  1  block enable; when low, state frozen and request low.
- ssm_max_se_size  in  8  bits taken per push, 1..MAX_SE_W; static while enabled.
- mux_word_request  out  1  block can accept a mux word this cycle.
- mux_word_valid  in  1  mux word present; push occurs only when valid & request.
- mux_word  in  MUX_WORD_W  payload; bits [ssm_max_se_size-1:0] used; bit ssm_max_se_size-1 is earliest in stream.
- data_to_be_parsed  out  FS_W  buffer; bit FS_W-1 is next bit to parse; bits below top `fullness` are 0.
- fullness  out  FULL_W  valid bit count in data_to_be_parsed.
- ready  out  1  registered; fullness ≥ ssm_max_se_size.
- size_to_remove  in  FULL_W  bits consumed by the parser this cycle.
- size_to_remove_valid  in  1  qualifies size_to_remove.
- err_underflow  out  1  sticky; present only with SSM_FS_ERR_CHECK_EN, else tied 0.

## Operation
- State: buf_r[FS_W-1:0], fullness_r[FULL_W-1:0], ready_r, err_r. data_to_be_parsed = buf_r; fullness = fullness_r.
- Request, combinational from registers only:
  - mux_word_request = en & ~flush & ~rst & (fullness_r + ssm_max_se_size ≤ FS_W).
  - There is no combinational path from size_to_remove.
- Per cycle with en high and no flush/rst:
  - pull = size_to_remove_valid ? size_to_remove : 0
  - push = mux_word_valid & mux_word_request
- Pull is applied first:
  - tmp = buf_r << pull, zero-filled from the LSB.
  - f1 = fullness_r − pull.
- If push:
  - bits [ssm_max_se_size-1:0] of mux_word are placed at tmp[FS_W-1-f1 -: ssm_max_se_size].
  - fullness_next = f1 + ssm_max_se_size.
- Otherwise buf and fullness take tmp and f1.
- mux_word_valid without request is ignored, with no state change.
- When en is low, push and pull are both ignored.
- Priority: rst > flush > en. Under rst or flush: buf_r=0, fullness_r=0, ready_r=0, err_r=0.
- Arithmetic is performed at FULL_W+1 bits internally. Overflow cannot occur given the request rule.

## Timing
- Reset values: mux_word_request=0 while rst is high; data_to_be_parsed=0; fullness=0; ready=0; err_underflow=0.
- Push latency: a word accepted in cycle t appears in data_to_be_parsed and fullness at t+1.
- Pull: size_to_remove in cycle t refers to data_to_be_parsed as seen in cycle t. The shifted result is visible at t+1. Back-to-back pulls every cycle are supported.
- ready at t+1 reflects fullness_r at t, i.e. it lags fullness by one cycle.
- Simultaneous push and pull in the same cycle produce a single combined update. Pull with size 0 is a no-op.
- Pull equal to fullness_r yields an empty buffer. When fullness_r=0 and push happens in the same cycle, the word lands at bit FS_W-1.
- With defaults (FS_W=495) and se=248, request is high iff fullness_r ≤ 247.
- Flush asserted mid-stream clears state the next cycle; request drops in the flush cycle itself.

## Configuration
- SSM_FS_ERR_CHECK_EN defined:
  - pull > fullness_r sets err_underflow, which is sticky until rst or flush.
  - The pull is clamped to fullness_r, so fullness becomes 0 and the buffer becomes all 0.
- Undefined:
  - No comparator; err_underflow is tied 0.
  - An illegal pull wraps fullness modulo 2^FULL_W; the behaviour is unsupported.

## Test plan
- Reset then en=1, se=248, valid held high: request high at t0, push, fullness=248 at t1, request low at t1 (248>247), ready=1 at t2.
- se=8, push 8'hA5 then 8'h3C, no pulls: fullness=16, data_to_be_parsed[494:479]=16'hA53C, lower bits 0.
- With fullness=16 holding A53C, pull 4 and push 8'hFF in the same cycle: fullness=20, top 20 bits = 20'h53CFF.
- mux_word_valid=1 while request=0 (fullness=300, se=248): no change to fullness or data.
- Flush at fullness=120 with a simultaneous push and pull: next cycle fullness=0, data=0, ready=0.
- With SSM_FS_ERR_CHECK_EN, fullness=10, pull 12: err_underflow=1 and fullness=0 next cycle, held until flush. Without the macro, err_underflow stays 0.
